// File: rtl/iiitb_bit_serializer.sv
// ---------------------------------------------------------------------------
// iiitb_bit_serializer
//
// Parallel-to-serial front end for the 1010 sequence detector. WIDTH-bit
// words are accepted over a valid/ready handshake and shifted out one bit
// per enabled clock on dout. Consecutive words are sent with no idle bit
// between them. While no data bit is being sent, dout is held at 0 so the
// downstream detector sits in its reset state.
//
// Optional feature (compile-time macro SER_PARITY_EN): after the WIDTH data
// bits, one even-parity bit (XOR of the word) is sent as a further valid
// bit. word_done and the load_ready lookahead then move to that bit.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   en          bit strobe; when low all state holds
//   load_data   parallel word, sampled only on the accepting edge
//   load_valid  load_data is valid
//   load_ready  a word can be accepted this cycle (combinational)
//   dout        serial bit (registered)
//   dout_valid  dout carries a data/parity bit (registered)
//   busy        a word is in flight
//   word_done   one-cycle pulse while the last bit of a word is on dout
// ---------------------------------------------------------------------------
module iiitb_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

`ifdef SER_PARITY_EN
    localparam int LIMIT = WIDTH + 1;
`else
    localparam int LIMIT = WIDTH;
`endif
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             dout_s;
    logic             dout_valid_s;
    logic             word_done_s;
    logic             last_s;
    logic             accept_s;
`ifdef SER_PARITY_EN
    logic             par_r;
    logic             par_s;

    // Even parity bit of a word: XOR of all its bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // Bit of a word that goes out first, given the configured bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return word[WIDTH-1];
        end else begin
            return word[0];
        end
    endfunction

    // Word with its first-out bit removed, so the next bit moves into place.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return {word[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, word[WIDTH-1:1]};
        end
    endfunction

    // The final bit of the current word is on dout; the next enabled edge
    // either retires the word or launches the first bit of the next one.
    assign last_s     = (state_r == SHIFT) && (cnt_r == LIMIT_C);
    assign load_ready = (state_r == IDLE) || (last_s && en);
    assign accept_s   = load_valid && load_ready && en;
    assign busy       = (state_r == SHIFT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (en && last_s && !accept_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Next values of the shift register, counter and registered outputs.
    always_comb begin
        shreg_s      = shreg_r;
        cnt_s        = cnt_r;
        dout_s       = dout;
        dout_valid_s = dout_valid;
        word_done_s  = 1'b0;
`ifdef SER_PARITY_EN
        par_s        = par_r;
`endif
        if (!en) begin
            // Stalled: hold everything; word_done only ever lasts one cycle.
            word_done_s = 1'b0;
        end else if (accept_s) begin
            // Accepting edge launches the first bit of the new word.
            shreg_s      = shift_word(load_data);
            dout_s       = first_bit(load_data);
            dout_valid_s = 1'b1;
            cnt_s        = ONE_C;
`ifdef SER_PARITY_EN
            par_s        = even_parity(load_data);
`endif
        end else if ((state_r == SHIFT) && !last_s) begin
            shreg_s      = shift_word(shreg_r);
            dout_s       = first_bit(shreg_r);
            dout_valid_s = 1'b1;
            cnt_s        = cnt_r + ONE_C;
            word_done_s  = ((cnt_r + ONE_C) == LIMIT_C);
`ifdef SER_PARITY_EN
            // All data bits are out: the stored parity bit goes next.
            if (cnt_r == CW'(WIDTH)) begin
                dout_s = par_r;
            end else begin
                dout_s = first_bit(shreg_r);
            end
`endif
        end else begin
            // Idle, or word retired with nothing queued: line goes quiet.
            dout_s       = 1'b0;
            dout_valid_s = 1'b0;
            cnt_s        = ZERO_C;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r    <= {WIDTH{1'b0}};
            cnt_r      <= ZERO_C;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
`ifdef SER_PARITY_EN
            par_r      <= 1'b0;
`endif
        end else begin
            shreg_r    <= shreg_s;
            cnt_r      <= cnt_s;
            dout       <= dout_s;
            dout_valid <= dout_valid_s;
            word_done  <= word_done_s;
`ifdef SER_PARITY_EN
            par_r      <= par_s;
`endif
        end
    end

endmodule

// File: tb/tb_iiitb_bit_serializer.sv
// Self-checking bench for iiitb_bit_serializer. Two instances (MSB-first and
// LSB-first) share one stimulus; a queue-based reference model predicts
// every output cycle by cycle.
module tb_iiitb_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         load_valid;
    logic [W-1:0] load_data;

    logic ready_m, dout_m, dv_m, busy_m, wd_m;
    logic ready_l, dout_l, dv_l, busy_l, wd_l;

    iiitb_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .en(en), .load_data(load_data),
        .load_valid(load_valid), .load_ready(ready_m), .dout(dout_m),
        .dout_valid(dv_m), .busy(busy_m), .word_done(wd_m)
    );

    iiitb_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .en(en), .load_data(load_data),
        .load_valid(load_valid), .load_ready(ready_l), .dout(dout_l),
        .dout_valid(dv_l), .busy(busy_l), .word_done(wd_l)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits still to be shown; element 0 is on dout now.
    bit qm[$];
    bit ql[$];
    bit wd_exp = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ones_parity(input logic [W-1:0] w);
        int c = 0;
        for (int i = 0; i < W; i++) c += int'(w[i]);
        return (c % 2) == 1;
    endfunction

    task automatic check_model();
        chk("m_dout",  dout_m, (qm.size() > 0) ? qm[0] : 1'b0);
        chk("m_valid", dv_m,   qm.size() > 0);
        chk("m_busy",  busy_m, qm.size() > 0);
        chk("m_done",  wd_m,   wd_exp);
        chk("l_dout",  dout_l, (ql.size() > 0) ? ql[0] : 1'b0);
        chk("l_valid", dv_l,   ql.size() > 0);
        chk("l_done",  wd_l,   wd_exp);
    endtask

    // One clock: check ready before the edge, advance the model, check after.
    task automatic step();
        bit rdy;
        #1;
        rdy = (qm.size() == 0) || (en && qm.size() == 1);
        chk("m_ready", ready_m, rdy);
        chk("l_ready", ready_l, rdy);
        @(posedge clk);
        if (en) begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (load_valid && rdy) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(load_data[W-1-i]);
                    ql.push_back(load_data[i]);
                end
`ifdef SER_PARITY_EN
                qm.push_back(ones_parity(load_data));
                ql.push_back(ones_parity(load_data));
`endif
            end
            wd_exp = (qm.size() == 1);
        end else begin
            wd_exp = 1'b0;
        end
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        qm.delete();
        ql.delete();
        wd_exp = 1'b0;
        check_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        load_valid = 1'b0;
        en = 1'b1;
        repeat (NB + 2) step();
    endtask

    typedef struct {
        bit           en;
        bit           valid;
        logic [W-1:0] data;
        bit           dout;
        bit           dv;
        bit           wd;
        bit           busy;
    } vec_t;

    function automatic vec_t mk(input bit e, input bit v, input logic [W-1:0] d,
                                input bit o, input bit ov, input bit od, input bit ob);
        vec_t r;
        r.en = e; r.valid = v; r.data = d;
        r.dout = o; r.dv = ov; r.wd = od; r.busy = ob;
        return r;
    endfunction

    vec_t tbl[10];

    initial begin
        logic [7:0]      seq;
        logic [2*NB-1:0] bb_exp;
        logic [NB-1:0]   exp_v;
        logic [NB-1:0]   got;
        int              rdy_cnt;
        int              wd_cnt;
        int              nbits;

        reset = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = '0;
        #1;
        check_model();
        chk("rst_ready", ready_m, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic MSB-first word 8'hA5 from a table.
        seq = 8'b10100101;
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1'b1, i == 0, 8'hA5, seq[7-i], 1'b1, i == NB - 1, 1'b1);
`ifdef SER_PARITY_EN
        tbl[8] = mk(1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
`else
        tbl[8] = mk(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        tbl[9] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            en = tbl[r].en; load_valid = tbl[r].valid; load_data = tbl[r].data;
            step();
            chk("tbl_dout",  dout_m, tbl[r].dout);
            chk("tbl_valid", dv_m,   tbl[r].dv);
            chk("tbl_done",  wd_m,   tbl[r].wd);
            chk("tbl_busy",  busy_m, tbl[r].busy);
        end

        // Back-to-back 8'h0A then 8'hA0 with load_valid held.
`ifdef SER_PARITY_EN
        bb_exp = 18'b000010100101000000;
`else
        bb_exp = 16'b0000101010100000;
`endif
        rdy_cnt = 0; wd_cnt = 0;
        en = 1'b1; load_valid = 1'b1; load_data = 8'h0A;
        for (int k = 0; k < 2 * NB; k++) begin
            #1;
            if (busy_m && ready_m) rdy_cnt++;
            step();
            chk("b2b_bit", dout_m, bb_exp[2*NB-1-k]);
            chk("b2b_valid", dv_m, 1'b1);
            if (wd_m) wd_cnt++;
            if (k == 0) load_data = 8'hA0;
            if (k == NB) load_valid = 1'b0;
        end
        chk_int("b2b_ready_pulses", rdy_cnt, 1);
        chk_int("b2b_done_pulses", wd_cnt, 2);
        drain();

        // Stall: en toggles during 8'hC3.
`ifdef SER_PARITY_EN
        exp_v = 9'b110000110;
`else
        exp_v = 8'b11000011;
`endif
        en = 1'b1; load_valid = 1'b1; load_data = 8'hC3;
        step();
        load_valid = 1'b0;
        got = '0; got[0] = dout_m; nbits = 1; wd_cnt = 0;
        for (int j = 0; j < 2 * NB; j++) begin
            en = j[0];
            step();
            if (en && dv_m) begin
                got = {got[NB-2:0], dout_m};
                nbits++;
            end
            if (wd_m) wd_cnt++;
        end
        chk_int("stall_bits", int'(got), int'(exp_v));
        chk_int("stall_count", nbits, NB);
        chk_int("stall_done_cycles", wd_cnt, 1);
        drain();

        // Reset after three bits of 8'hFF, then 8'h5A from bit 0.
        en = 1'b1; load_valid = 1'b1; load_data = 8'hFF;
        step();
        load_valid = 1'b0;
        step(); step();
        do_reset();
        chk("rst_dout", dout_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
`ifdef SER_PARITY_EN
        exp_v = 9'b010110100;
`else
        exp_v = 8'b01011010;
`endif
        load_valid = 1'b1; load_data = 8'h5A;
        got = '0;
        for (int k = 0; k < NB; k++) begin
            step();
            load_valid = 1'b0;
            got = {got[NB-2:0], dout_m};
        end
        chk_int("post_rst_bits", int'(got), int'(exp_v));
        drain();

        // LSB-first: 8'h01 on the second instance.
`ifdef SER_PARITY_EN
        exp_v = 9'b100000001;
`else
        exp_v = 8'b10000000;
`endif
        load_valid = 1'b1; load_data = 8'h01;
        got = '0;
        for (int k = 0; k < NB; k++) begin
            step();
            load_valid = 1'b0;
            got = {got[NB-2:0], dout_l};
        end
        chk_int("lsb_bits", int'(got), int'(exp_v));
        drain();

`ifdef SER_PARITY_EN
        // Parity bit of 8'h07 is 1, with word_done on the ninth bit.
        load_valid = 1'b1; load_data = 8'h07;
        got = '0;
        for (int k = 0; k < NB; k++) begin
            step();
            load_valid = 1'b0;
            got = {got[NB-2:0], dout_m};
        end
        chk_int("par07_bits", int'(got), int'(9'b000001111));
        chk("par07_done", wd_m, 1'b1);
        drain();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            en = ($urandom_range(0, 3) != 0);
            load_valid = ($urandom_range(0, 2) != 0);
            load_data = W'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
